// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// Ports: clk, rst_n, rx in; rd_en pop; rd_data/empty/full/count FIFO view; error pulses.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 87,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_MID   = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_prev;
    logic [CW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    logic bit_done;
    logic push;
    logic pop;

    assign bit_done = (bit_cnt == BIT_LAST);
    assign pop      = rd_en && !empty;
    // A full FIFO still accepts the word when a pop frees the slot this cycle.
    assign push     = (state == S_STOP) && bit_done && rxs && !par_bad
                   && (!full || rd_en);

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Synchronizer; rxs_prev provides the falling-edge reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    // Edge, not level: a line stuck low never re-triggers.
                    if (!rxs && rxs_prev)
                        state <= S_START;
                end
                S_START: begin
                    if (bit_cnt == BIT_MID) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                        state   <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == DATA_LAST)
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        par_bad <= ((^shreg) ^ rxs) != PAR_ODD;
                        state   <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= S_IDLE;
                        if (!rxs)
                            frame_err <= 1'b1;
                        else if (par_bad)
                            parity_err <= 1'b1;
                        else if (full && !rd_en)
                            overrun <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one instance without parity, one with even parity.
// Stimulus queues expected words; a negedge monitor compares every pop and counts flag pulses.
module tb_uart_rx_fifo;

    localparam int CD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line = 1'b1;
    logic sel = 1'b0;
    logic rd_en0 = 1'b0;
    logic rd_en1 = 1'b0;
    logic rx0, rx1;

    logic [7:0] rd_data0, rd_data1;
    logic       empty0, empty1, full0, full1;
    logic [2:0] count0, count1;
    logic       fe0, pe0, ov0, fe1, pe1, ov1;

    assign rx0 = sel ? 1'b1 : line;
    assign rx1 = sel ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rd_en(rd_en0),
        .rd_data(rd_data0), .empty(empty0), .full(full0), .count(count0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rd_en(rd_en1),
        .rd_data(rd_data1), .empty(empty1), .full(full1), .count(count1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int c_fe0 = 0, c_pe0 = 0, c_ov0 = 0;
    int c_fe1 = 0, c_pe1 = 0, c_ov1 = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    time t_fall = 0;
    time t_empty = 0;
    logic e0_q = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted read, tallies flag pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en0 && !empty0) begin
                if (exp0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pop0: got 0x%0h, expected no data", rd_data0);
                end else begin
                    chk("pop0", int'(rd_data0), int'(exp0.pop_front()));
                end
            end
            if (rd_en1 && !empty1) begin
                if (exp1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pop1: got 0x%0h, expected no data", rd_data1);
                end else begin
                    chk("pop1", int'(rd_data1), int'(exp1.pop_front()));
                end
            end
            c_fe0 += int'(fe0);
            c_pe0 += int'(pe0);
            c_ov0 += int'(ov0);
            c_fe1 += int'(fe1);
            c_pe1 += int'(pe1);
            c_ov1 += int'(ov1);
            if (e0_q && !empty0)
                t_empty = $time;
        end
        e0_q = empty0;
    end

    // par < 0 means no parity bit.
    task automatic send(input logic [7:0] d, input int par, input logic stop);
        @(posedge clk);
        #1;
        line = 1'b0;
        t_fall = $time;
        repeat (CD) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            repeat (CD) @(posedge clk);
            #1;
        end
        if (par >= 0) begin
            line = par[0];
            repeat (CD) @(posedge clk);
            #1;
        end
        line = stop;
        repeat (CD) @(posedge clk);
        #1;
        line = 1'b1;
    endtask

    task automatic pop0();
        @(posedge clk);
        #1 rd_en0 = 1'b1;
        @(posedge clk);
        #1 rd_en0 = 1'b0;
    endtask

    task automatic pop1();
        @(posedge clk);
        #1 rd_en1 = 1'b1;
        @(posedge clk);
        #1 rd_en1 = 1'b0;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_empty"}, int'(empty0), 1);
        chk({tag, "_full"}, int'(full0), 0);
        chk({tag, "_count"}, int'(count0), 0);
        chk({tag, "_rd_data"}, int'(rd_data0), 0);
        chk({tag, "_flags"}, int'({fe0, pe0, ov0}), 0);
    endtask

    int fe_b, pe_b, ov_b, lat;
    logic [7:0] fill [4];

    initial begin
        fill[0] = 8'h11;
        fill[1] = 8'h22;
        fill[2] = 8'h33;
        fill[3] = 8'h44;

        repeat (3) @(posedge clk);
        #1;
        chk_reset0("rst");
        chk("rst_empty1", int'(empty1), 1);
        chk("rst_count1", int'(count1), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single 0xA5 frame, latency and contents
        t_empty = 0;
        exp0.push_back(8'hA5);
        send(8'hA5, -1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        lat = int'((t_empty - t_fall) / 10);
        n_chk++;
        if (lat < 153 || lat > 155) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected 153..155", lat);
        end
        chk("a5_count", int'(count0), 1);
        chk("a5_head", int'(rd_data0), 8'hA5);
        chk("a5_flags", c_fe0 + c_pe0 + c_ov0, 0);
        pop0();
        #1;
        chk("a5_empty_after_pop", int'(empty0), 1);

        // Fill to full, then overrun on the fifth frame
        for (int i = 0; i < 4; i++) begin
            exp0.push_back(fill[i]);
            send(fill[i], -1, 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("fill_full", int'(full0), 1);
        chk("fill_count", int'(count0), 4);
        ov_b = c_ov0;
        send(8'h55, -1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("overrun_pulse", c_ov0 - ov_b, 1);
        chk("overrun_count", int'(count0), 4);
        repeat (4) pop0();
        #1;
        chk("drain_empty", int'(empty0), 1);

        // Full FIFO with a pop on the push cycle of 0x66
        for (int i = 0; i < 4; i++) begin
            exp0.push_back(fill[i]);
            send(fill[i], -1, 1'b1);
        end
        exp0.push_back(8'h66);
        ov_b = c_ov0;
        fork
            send(8'h66, -1, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 rd_en0 = 1'b1;
                @(posedge clk);
                #1 rd_en0 = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("simul_no_overrun", c_ov0 - ov_b, 0);
        chk("simul_count", int'(count0), 4);
        repeat (4) pop0();
        #1;
        chk("simul_drain_empty", int'(empty0), 1);

        // Bad stop bit, stuck-low line, short glitch
        fe_b = c_fe0;
        send(8'h5A, -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("frame_err_pulse", c_fe0 - fe_b, 1);
        chk("frame_err_no_push", int'(count0), 0);
        @(posedge clk);
        #1 line = 1'b0;
        repeat (400) @(posedge clk);
        #1 line = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("stuck_low_one_err", c_fe0 - fe_b, 2);
        chk("stuck_low_no_push", int'(count0), 0);
        fe_b = c_fe0;
        pe_b = c_pe0;
        ov_b = c_ov0;
        @(posedge clk);
        #1 line = 1'b0;
        repeat (3) @(posedge clk);
        #1 line = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("glitch_flags", (c_fe0 - fe_b) + (c_pe0 - pe_b) + (c_ov0 - ov_b), 0);
        chk("glitch_no_push", int'(count0), 0);

        // Even parity on the second instance
        sel = 1'b1;
        pe_b = c_pe1;
        send(8'h07, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("parity_err_pulse", c_pe1 - pe_b, 1);
        chk("parity_err_no_push", int'(empty1), 1);
        exp1.push_back(8'h07);
        send(8'h07, 1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("parity_ok_count", int'(count1), 1);
        chk("parity_ok_no_err", c_pe1 - pe_b, 1);
        chk("parity_ok_other_flags", c_fe1 + c_ov1, 0);
        pop1();
        #1;
        chk("parity_empty_after_pop", int'(empty1), 1);
        sel = 1'b0;
        repeat (5) @(posedge clk);

        // Reset in the middle of a frame with one word queued
        exp0.push_back(8'h99);
        send(8'h99, -1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_count", int'(count0), 1);
        fe_b = c_fe0;
        pe_b = c_pe0;
        ov_b = c_ov0;
        fork
            send(8'hFF, -1, 1'b1);
            begin
                @(posedge clk);
                repeat (88) @(posedge clk);
                #1 rst_n = 1'b0;
                exp0.delete();
                #2;
                chk_reset0("midrst");
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        repeat (50) @(posedge clk);
        #1;
        chk("post_reset_count", int'(count0), 0);
        chk("post_reset_flags", (c_fe0 - fe_b) + (c_pe0 - pe_b) + (c_ov0 - ov_b), 0);
        exp0.push_back(8'h3C);
        send(8'h3C, -1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_rx_count", int'(count0), 1);
        chk("post_reset_rx_head", int'(rd_data0), 8'h3C);
        pop0();
        repeat (2) @(posedge clk);
        #1;
        chk("queue0_drained", exp0.size(), 0);
        chk("queue1_drained", exp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 87: clock cycles per UART bit; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter FIFO_DEPTH, default 4: number of FIFO entries; power of two, legal range 2..64.
REQ-005 clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 rx, input, 1 bit: serial line; asynchronous to clk; idles high.
REQ-008 rd_en, input, 1 bit: pop request; ignored when empty.
REQ-009 rd_data, output, DATA_BITS bits: head-of-FIFO word (first-word-fall-through).
REQ-010 empty, output, 1 bit: FIFO holds zero entries.
REQ-011 full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-012 count, output, clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-013 frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-014 parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-015 overrun, output, 1 bit: one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value rxs.
REQ-017 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, and a bit counter SHALL count 0..CLK_DIV-1.
- IDLE -> START on rxs high-to-low; bit counter clears.
REQ-018 In START, at bit count CLK_DIV/2-1 (mid-bit), rxs SHALL be sampled.
- rxs low: go to DATA with the bit counter cleared.
- rxs high: treat as a glitch and return to IDLE with no flag.
REQ-019 In DATA, each bit SHALL be sampled when the bit counter reaches CLK_DIV-1.
- DATA_BITS samples are taken, LSB first, into a shift register.
- Then go to PARITY if PARITY != 0, else go to STOP.
REQ-020 PARITY SHALL sample one bit.
- Mismatch is judged against the XOR of the data bits: even requires data^p = 0; odd requires data^p = 1.
- A mismatch is held internally until STOP completes.
REQ-021 STOP SHALL sample one bit, then return to IDLE, taking exactly one of these actions in that cycle:
- stop bit = 0: frame_err = 1 and the word is discarded.
- else, parity mismatch held: parity_err = 1 and the word is discarded.
- else, FIFO full and no simultaneous pop: overrun = 1 and the word is discarded.
- else: the word is pushed.
REQ-022 Total receive latency SHALL be 2 + CLK_DIV/2 + (DATA_BITS + (PARITY!=0) + 1)·CLK_DIV cycles ±1, measured from the rx falling edge to empty deasserting.
REQ-023 Push and pop in the same cycle SHALL both succeed, including when full, and count SHALL be unchanged.
REQ-024 Pop SHALL take effect at the clock edge; rd_data SHALL present the next entry on the following cycle; a pop while empty SHALL change nothing.
REQ-025 The read and write pointers SHALL be clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.
REQ-026 A line held low for a whole frame SHALL give frame_err; reception SHALL restart only after rxs returns high and then falls again.

Reset
REQ-027 While rst_n = 0, the following SHALL hold:
- FSM = IDLE and counters = 0.
- Both synchronizer flops = 1.
- Pointers = 0, count = 0, empty = 1, full = 0.
- frame_err = parity_err = overrun = 0, rd_data = 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no push and no flag; after release, the block waits for a fresh falling edge.

Verification (CLK_DIV=16, DATA_BITS=8, FIFO_DEPTH=4 unless stated)
REQ-029 Send 0xA5 with PARITY=0 -> empty falls about 154 cycles after the start edge; rd_data = 0xA5; count = 1; no flags.
REQ-030 PARITY=1; send 0x07 with parity bit 0 -> parity_err pulses once; empty stays 1. Resend with parity bit 1 -> 0x07 is pushed.
REQ-031 Send 0x11,0x22,0x33,0x44,0x55 with no reads -> full after the 4th; overrun pulses on the 5th; popping four times yields 0x11..0x44 in order.
REQ-032 Fill to full, then assert rd_en in the STOP-complete cycle of the next frame 0x66 -> no overrun; count stays 4; the last entry is 0x66.
REQ-033 Send a frame with stop bit 0 -> frame_err pulses; no push. Then a 3-cycle low glitch -> no flag and no push.
REQ-034 Pulse rst_n low at DATA bit 4 of a frame -> all outputs at reset values. A following 0x3C frame is received correctly.
